// File: rtl/chime_sequencer.sv
// Doorbell chime controller: arbitrates front/back presses and sequences the
// two-sound mux. Define CHIME_PENDING_EN to queue presses that arrive while busy.
module chime_sequencer #(
  parameter int TONE_CYCLES = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int CW          = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic front_req,
  input  logic back_req,
  output logic sel,
  output logic tone_en,
  output logic busy,
  output logic src,
  output logic done
);

  typedef enum logic [1:0] {IDLE, TONE_A, TONE_B, GAP} state_t;

  localparam logic [CW-1:0] TONE_LOAD = CW'(TONE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          front_q, back_q;
  logic          src_q, src_n;
  logic          done_q, done_n;
  logic          front_press, back_press, last;

`ifdef CHIME_PENDING_EN
  logic          pend_front, pend_front_n;
  logic          pend_back, pend_back_n;
`endif

  assign front_press = front_req & ~front_q;
  assign back_press  = back_req & ~back_q;
  assign last        = (cnt == '0);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      front_q    <= 1'b0;
      back_q     <= 1'b0;
      src_q      <= 1'b0;
      done_q     <= 1'b0;
`ifdef CHIME_PENDING_EN
      pend_front <= 1'b0;
      pend_back  <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      front_q    <= front_req;
      back_q     <= back_req;
      src_q      <= src_n;
      done_q     <= done_n;
`ifdef CHIME_PENDING_EN
      pend_front <= pend_front_n;
      pend_back  <= pend_back_n;
`endif
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    src_n   = src_q;
    done_n  = 1'b0;
`ifdef CHIME_PENDING_EN
    pend_front_n = pend_front;
    pend_back_n  = pend_back;
    // Presses while a chime is in progress are remembered, one per door.
    if (state != IDLE) begin
      if (front_press) pend_front_n = 1'b1;
      if (back_press)  pend_back_n  = 1'b1;
    end
`endif
    case (state)
      IDLE: begin
        if (front_press) begin
          state_n = TONE_A;
          cnt_n   = TONE_LOAD;
          src_n   = 1'b0;
`ifdef CHIME_PENDING_EN
          if (back_press) pend_back_n = 1'b1;
`endif
        end else if (back_press) begin
          state_n = TONE_B;
          cnt_n   = TONE_LOAD;
          src_n   = 1'b1;
        end
      end
      TONE_A: begin
        if (last) begin
          state_n = TONE_B;
          cnt_n   = TONE_LOAD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      TONE_B: begin
        if (last) begin
          state_n = GAP;
          cnt_n   = GAP_LOAD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      GAP: begin
        if (last) begin
          state_n = IDLE;
          done_n  = 1'b1;
`ifdef CHIME_PENDING_EN
          if (pend_front) begin
            state_n      = TONE_A;
            cnt_n        = TONE_LOAD;
            src_n        = 1'b0;
            pend_front_n = 1'b0;
          end else if (pend_back) begin
            state_n     = TONE_B;
            cnt_n       = TONE_LOAD;
            src_n       = 1'b1;
            pend_back_n = 1'b0;
          end
`endif
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    tone_en = 1'b0;
    sel     = 1'b0;
    busy    = 1'b0;
    case (state)
      TONE_A: begin
        tone_en = 1'b1;
        busy    = 1'b1;
      end
      TONE_B: begin
        tone_en = 1'b1;
        sel     = 1'b1;
        busy    = 1'b1;
      end
      GAP:     busy = 1'b1;
      default: ;
    endcase
  end

  assign src  = src_q;
  assign done = done_q;

endmodule

// File: tb/tb_chime_sequencer.sv
// Self-checking bench for chime_sequencer (default build, pending queue disabled).
module tb_chime_sequencer;

  logic clk = 1'b0;
  logic rst_n, front_req, back_req;
  logic sel, tone_en, busy, src, done;
  logic s_front, s_back;
  logic s_sel, s_tone_en, s_busy, s_src, s_done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  chime_sequencer #(.TONE_CYCLES(8), .GAP_CYCLES(4), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .front_req(front_req), .back_req(back_req),
    .sel(sel), .tone_en(tone_en), .busy(busy), .src(src), .done(done)
  );

  // One-cycle tones and gap to cover the shortest legal durations.
  chime_sequencer #(.TONE_CYCLES(1), .GAP_CYCLES(1), .CW(8)) dut_short (
    .clk(clk), .rst_n(rst_n), .front_req(s_front), .back_req(s_back),
    .sel(s_sel), .tone_en(s_tone_en), .busy(s_busy), .src(s_src), .done(s_done)
  );

  typedef struct {
    logic       rst_n;
    logic       front;
    logic       back;
    logic [4:0] exp;   // {tone_en, sel, busy, src, done}
  } vec_t;

  vec_t vecs[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (tone_en,sel,busy,src,done)", name, act, exp);
  endtask

  function automatic logic [4:0] obs();
    return {tone_en, sel, busy, src, done};
  endfunction

  function automatic logic [4:0] obs_short();
    return {s_tone_en, s_sel, s_busy, s_src, s_done};
  endfunction

  // Expected outputs i cycles after the press edge, for TONE=8, GAP=4.
  function automatic logic [4:0] exp_vec(input bit is_back, input int i);
    int   tone_len = is_back ? 8 : 16;
    int   end_i    = tone_len + 4;
    logic t        = (i < tone_len);
    logic s        = t && (is_back || i >= 8);
    logic b        = (i < end_i);
    logic d        = (i == end_i);
    return {t, s, b, is_back, d};
  endfunction

  // Called right after the press edge; stops on the done cycle.
  task automatic run_chime(input string tag, input bit is_back, input int back_at);
    int end_i = (is_back ? 8 : 16) + 4;
    for (int i = 0; i <= end_i; i++) begin
      check($sformatf("%s[%0d]", tag, i), obs(), exp_vec(is_back, i));
      if (i == back_at) back_req = 1'b1;
      if (i < end_i) step();
    end
  endtask

  task automatic expect_idle(input string tag, input int n, input logic exp_src);
    for (int i = 0; i < n; i++) begin
      step();
      check($sformatf("%s[%0d]", tag, i), obs(), {4'b0000, 1'b0} | {3'b000, exp_src, 1'b0});
    end
  endtask

  initial begin
    rst_n = 1'b0; front_req = 1'b0; back_req = 1'b0;
    s_front = 1'b0; s_back = 1'b0;

    // Reset then a back chime, one row per clock.
    vecs[0] = '{1'b0, 1'b0, 1'b0, 5'b00000};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 5'b00000};
    for (int r = 2; r <= 9; r++)  vecs[r] = '{1'b1, 1'b0, 1'b1, 5'b11110};
    for (int r = 10; r <= 13; r++) vecs[r] = '{1'b1, 1'b0, 1'b0, 5'b00110};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 5'b00011};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 5'b00010};

    for (int r = 0; r < 16; r++) begin
      rst_n     = vecs[r].rst_n;
      front_req = vecs[r].front;
      back_req  = vecs[r].back;
      step();
      check($sformatf("vec%0d", r), obs(), vecs[r].exp);
    end

    // Front ding-dong; the level stays high past the chime without retriggering.
    front_req = 1'b1;
    step();
    run_chime("front", 1'b0, -1);
    expect_idle("front_held", 3, 1'b0);
    front_req = 1'b0;

    // Same-edge tie: front wins, back press is lost.
    step();
    front_req = 1'b1; back_req = 1'b1;
    step();
    run_chime("tie", 1'b0, -1);
    front_req = 1'b0; back_req = 1'b0;
    expect_idle("tie_after", 10, 1'b0);

    // Back press mid-chime is ignored.
    front_req = 1'b1;
    step();
    run_chime("busy_ign", 1'b0, 5);
    front_req = 1'b0; back_req = 1'b0;
    expect_idle("busy_after", 10, 1'b0);

    // Back chime to set src, then reset mid front chime.
    back_req = 1'b1;
    step();
    run_chime("back1", 1'b1, -1);
    back_req = 1'b0;
    step();
    front_req = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("pre_rst[%0d]", i), obs(), exp_vec(1'b0, i));
      step();
    end
    rst_n = 1'b0;
    step();
    check("in_rst", obs(), 5'b00000);
    front_req = 1'b0;
    rst_n = 1'b1;
    expect_idle("post_rst_idle", 6, 1'b0);
    front_req = 1'b1;
    step();
    run_chime("post_rst", 1'b0, -1);
    front_req = 1'b0;

    // Press sampled on the done cycle starts the next chime immediately.
    step();
    back_req = 1'b1;
    step();
    run_chime("back2", 1'b1, -1);
    back_req = 1'b0; front_req = 1'b1;
    step();
    run_chime("front_on_done", 1'b0, -1);
    front_req = 1'b0;
    expect_idle("end_idle", 2, 1'b0);

    // Single-cycle tones and gap.
    s_front = 1'b1;
    step();
    check("short_a", obs_short(), 5'b10100);
    s_front = 1'b0;
    step();
    check("short_b", obs_short(), 5'b11100);
    step();
    check("short_gap", obs_short(), 5'b00100);
    step();
    check("short_done", obs_short(), 5'b00001);
    step();
    check("short_idle", obs_short(), 5'b00000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
